cpu_trace_probe: RTL and testbench
==================================

// Module: cpu_trace_probe
// PURPOSE
//  Parametrised trace/halt monitor that sits beside the single-cycle core in simulation and FPGA debug builds.
//  Every clock it samples the core's commit signals (pc, instr, register write-back) into a circular trace buffer.
//  It stops capturing a programmable number of entries after a PC trigger, detects program halt (PC stuck),
//  and keeps cycle/retire counters. Trace contents are read back through an indexed port.
// PARAMETERS
//  DATA_W      32  width of pc, instr, write-back data
//  DEPTH       16  trace entries; power of two, >=4
//  POST_CNT     8  entries captured after trigger, 0..DEPTH-1
//  HALT_IDLE    8  consecutive cycles with unchanged pc that declare halt, >=2
//  CNT_W       32  width of cycle/retire counters
// PORTS
//  clock       in   1            core clock; all state on rising edge
//  reset_n     in   1            asynchronous, active-low reset
//  pc          in   DATA_W       core pc this cycle
//  instr       in   DATA_W       instruction at pc
//  reg_write   in   1            core RegWrite this cycle
//  write_reg   in   5            destination register (chooserd)
//  write_data  in   DATA_W       register write-back value
//  mem_write   in   1            core MemWrite this cycle
//  arm         in   1            pulse: clear buffer, start capture (IDLE/DONE only)
//  trig_pc     in   DATA_W       pc value that fires the trigger
//  rd_idx      in   log2(DEPTH)  readback index, 0 = oldest valid entry
//  rd_pc       out  DATA_W       pc of entry rd_idx (combinational)
//  rd_instr    out  DATA_W       instr of entry rd_idx
//  rd_wb       out  DATA_W+7     {reg_write,mem_write,write_reg,write_data} of entry rd_idx
//  count       out  log2(DEPTH)+1 valid entries, 0..DEPTH
//  cycle_cnt   out  CNT_W        cycles since arm, saturating
//  retire_cnt  out  CNT_W        cycles with reg_write|mem_write since arm, saturating
//  triggered   out  1            trigger has fired since arm
//  halted      out  1            pc unchanged for HALT_IDLE consecutive cycles
//  done        out  1            capture finished (state DONE)
// BEHAVIOUR
//  Reset: state=IDLE; wr_ptr, count, cycle_cnt, retire_cnt, post counter, idle counter = 0;
//   triggered=halted=done=0; buffer contents don't-care; rd_* = entry at rd_idx (don't-care when count=0).
//  FSM: IDLE -arm-> ARMED; ARMED -trigger-> POST (or DONE if POST_CNT=0); POST -POST_CNT entries-> DONE;
//   ARMED/POST -halted rises-> DONE; DONE -arm-> ARMED. arm in ARMED/POST is ignored.
//  Arm cycle: count, pointers, counters, triggered, halted cleared; that cycle's sample is NOT written.
//  Capture (ARMED, POST): one entry per cycle written at wr_ptr; wr_ptr wraps DEPTH-1->0;
//   count increments to DEPTH then saturates (oldest overwritten). oldest = wr_ptr when count=DEPTH, else 0.
//  Trigger: in ARMED, pc==trig_pc samples the triggering entry itself, sets triggered next edge;
//   POST then writes exactly POST_CNT further entries (trigger entry excluded).
//  Halt: idle counter increments when pc equals previous-cycle pc, else reloads 0; halted set when
//   counter reaches HALT_IDLE-1 and stays set until arm/reset. Halt entry is written, then DONE.
//  Trigger and halt same cycle: triggered and halted both set, state -> DONE (halt wins).
//  Counters: cycle_cnt +1 per ARMED/POST cycle; retire_cnt +1 when reg_write|mem_write in ARMED/POST;
//   both saturate at all-ones; frozen in IDLE/DONE.
//  Readback: rd_idx addresses (oldest+rd_idx) mod DEPTH; zero-latency; rd_idx>=count returns don't-care.
//  reset_n asserted mid-capture: all state above returns to reset values immediately.
// TESTING
//  1 Reset, arm, pc 0,4,8..., trig_pc=0x100 unreachable, 20 cycles -> count=16, rd_idx0 pc=0x10, idx15 pc=0x4C, done=0.
//  2 DEPTH=16,POST_CNT=8, trigger at pc=0x40 (cycle 17) -> done after 8 more, rd_idx7 pc=0x40, idx15 pc=0x60.
//  3 pc held at 0x20 from cycle 5, HALT_IDLE=8 -> halted & done 7 cycles after first repeat, cycle_cnt freezes.
//  4 reg_write on 3 of 10 cycles, mem_write on 2 disjoint -> retire_cnt=5, cycle_cnt=10, rd_wb flags match.
//  5 pc==trig_pc in same cycle halt fires -> triggered=1, halted=1, done=1, no POST entries.
//  6 reset_n low mid-POST, then arm -> all outputs reset values, fresh capture starts from count=0.

Source files
------------

// File: rtl/cpu_trace_probe_if.sv
// Core commit bus observed by the trace probe: pc, instruction and write-back info, one beat per clock.
// The core side drives every field each cycle; the probe only samples.
interface cpu_trace_probe_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic              reg_write;
    logic [4:0]        write_reg;
    logic [DATA_W-1:0] write_data;
    logic              mem_write;

    modport master (
        output pc, instr, reg_write, write_reg, write_data, mem_write
    );

    modport slave (
        input  pc, instr, reg_write, write_reg, write_data, mem_write
    );
endinterface

// File: rtl/cpu_trace_probe.sv
// Trace/halt monitor: circular capture of core commits with PC trigger, post-trigger window, halt detect, counters.
// Latency: one-cycle capture, zero-cycle combinational readback; no backpressure, the core is sampled every clock.
module cpu_trace_probe #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int POST_CNT  = 8,
    parameter int HALT_IDLE = 8,
    parameter int CNT_W     = 32,
    localparam int IDX_W    = $clog2(DEPTH),
    localparam int WB_W     = DATA_W + 7
) (
    input  logic               clock,
    input  logic               reset_n,
    cpu_trace_probe_if.slave   commit,
    input  logic               arm,
    input  logic [DATA_W-1:0]  trig_pc,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [DATA_W-1:0]  rd_pc,
    output logic [DATA_W-1:0]  rd_instr,
    output logic [WB_W-1:0]    rd_wb,
    output logic [IDX_W:0]     count,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   retire_cnt,
    output logic               triggered,
    output logic               halted,
    output logic               done
);

    localparam int IDLE_W = $clog2(HALT_IDLE);
    localparam logic [IDX_W:0]    FULL      = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0]  POST_LAST = IDX_W'(POST_CNT > 0 ? POST_CNT - 1 : 0);
    localparam logic [IDLE_W-1:0] HALT_MARK = IDLE_W'(HALT_IDLE - 2);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    wr_ptr;
    logic [IDX_W-1:0]    post_cnt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [DATA_W-1:0]   prev_pc;

    logic [DATA_W-1:0]   pc_mem    [DEPTH];
    logic [DATA_W-1:0]   instr_mem [DEPTH];
    logic [WB_W-1:0]     wb_mem    [DEPTH];

    logic                capturing;
    logic                arm_ok;
    logic                same_pc;
    logic                trig_hit;
    logic                halt_hit;
    logic [IDX_W-1:0]    oldest;
    logic [IDX_W-1:0]    rd_addr;

    assign capturing = (state == S_ARMED) || (state == S_POST);
    assign arm_ok    = arm && ((state == S_IDLE) || (state == S_DONE));
    assign same_pc   = (commit.pc == prev_pc);
    assign trig_hit  = (state == S_ARMED) && (commit.pc == trig_pc);
    // The repeat that lifts the idle run to HALT_IDLE-1 is the halting sample.
    assign halt_hit  = capturing && same_pc && (idle_cnt == HALT_MARK);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            count      <= '0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            post_cnt   <= '0;
            idle_cnt   <= '0;
            prev_pc    <= '0;
            triggered  <= 1'b0;
            halted     <= 1'b0;
            done       <= 1'b0;
        end else begin
            prev_pc <= commit.pc;
            if (arm_ok) begin
                state      <= S_ARMED;
                wr_ptr     <= '0;
                count      <= '0;
                cycle_cnt  <= '0;
                retire_cnt <= '0;
                post_cnt   <= '0;
                idle_cnt   <= '0;
                triggered  <= 1'b0;
                halted     <= 1'b0;
                done       <= 1'b0;
            end else if (capturing) begin
                wr_ptr <= wr_ptr + IDX_W'(1);
                if (count != FULL) begin
                    count <= count + (IDX_W+1)'(1);
                end
                if (cycle_cnt != CNT_MAX) begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                end
                if ((commit.reg_write || commit.mem_write) && (retire_cnt != CNT_MAX)) begin
                    retire_cnt <= retire_cnt + CNT_W'(1);
                end
                idle_cnt <= same_pc ? idle_cnt + IDLE_W'(1) : '0;
                if (trig_hit) begin
                    triggered <= 1'b1;
                end
                // Halt takes priority over a trigger landing on the same sample.
                if (halt_hit) begin
                    halted <= 1'b1;
                    state  <= S_DONE;
                    done   <= 1'b1;
                end else if (trig_hit) begin
                    post_cnt <= '0;
                    if (POST_CNT == 0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_POST;
                    end
                end else if (state == S_POST) begin
                    if (post_cnt == POST_LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        post_cnt <= post_cnt + IDX_W'(1);
                    end
                end
            end
        end
    end

    // Buffer contents are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge clock) begin
        if (capturing) begin
            pc_mem[wr_ptr]    <= commit.pc;
            instr_mem[wr_ptr] <= commit.instr;
            wb_mem[wr_ptr]    <= {commit.reg_write, commit.mem_write, commit.write_reg, commit.write_data};
        end
    end

    // Once the buffer has wrapped, the next slot to be overwritten holds the oldest entry.
    assign oldest   = count[IDX_W] ? wr_ptr : '0;
    assign rd_addr  = oldest + rd_idx;
    assign rd_pc    = pc_mem[rd_addr];
    assign rd_instr = instr_mem[rd_addr];
    assign rd_wb    = wb_mem[rd_addr];

endmodule

// File: tb/tb_cpu_trace_probe.sv
// Bench for cpu_trace_probe: directed scenarios plus random commits, checked every cycle against a queue model.
module tb_cpu_trace_probe;
    localparam int DW        = 32;
    localparam int DEPTH     = 16;
    localparam int POST_CNT  = 8;
    localparam int HALT_IDLE = 8;
    localparam int SAT_W     = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    cpu_trace_probe_if #(.DATA_W(DW)) bus();

    logic          arm;
    logic [31:0]   trig_pc;
    logic [3:0]    rd_idx;
    logic [31:0]   rd_pc, rd_instr, cycle_cnt, retire_cnt;
    logic [38:0]   rd_wb;
    logic [4:0]    count;
    logic          triggered, halted, done;

    logic [31:0]   s_rd_pc, s_rd_instr;
    logic [38:0]   s_rd_wb;
    logic [4:0]    s_count;
    logic [SAT_W-1:0] s_cyc, s_ret;
    logic          s_trig, s_halt, s_done;

    cpu_trace_probe #(.DATA_W(DW), .DEPTH(DEPTH), .POST_CNT(POST_CNT), .HALT_IDLE(HALT_IDLE), .CNT_W(32)) dut (
        .clock(clock), .reset_n(reset_n), .commit(bus), .arm(arm), .trig_pc(trig_pc), .rd_idx(rd_idx),
        .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_wb(rd_wb), .count(count), .cycle_cnt(cycle_cnt),
        .retire_cnt(retire_cnt), .triggered(triggered), .halted(halted), .done(done));

    cpu_trace_probe #(.DATA_W(DW), .DEPTH(DEPTH), .POST_CNT(POST_CNT), .HALT_IDLE(HALT_IDLE), .CNT_W(SAT_W)) u_sat (
        .clock(clock), .reset_n(reset_n), .commit(bus), .arm(arm), .trig_pc(trig_pc), .rd_idx(rd_idx),
        .rd_pc(s_rd_pc), .rd_instr(s_rd_instr), .rd_wb(s_rd_wb), .count(s_count), .cycle_cnt(s_cyc),
        .retire_cnt(s_ret), .triggered(s_trig), .halted(s_halt), .done(s_done));

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [38:0] wb;
    } ent_t;

    ent_t        q[$];
    int          mode;       // 0 idle, 1 armed, 2 post, 3 done
    int          post_left;
    int          run;
    logic [31:0] prev;
    longint      m_cyc, m_ret;
    bit          m_trig, m_halt;

    function automatic void model_reset();
        q.delete();
        mode = 0; post_left = 0; run = 0; prev = '0;
        m_cyc = 0; m_ret = 0; m_trig = 0; m_halt = 0;
    endfunction

    function automatic void model_step();
        ent_t e;
        bit   cap, hit_t, hit_h;
        cap = (mode == 1) || (mode == 2);
        if (!cap && arm) begin
            q.delete();
            m_cyc = 0; m_ret = 0; m_trig = 0; m_halt = 0; run = 0;
            mode = 1;
        end else if (cap) begin
            run = (bus.pc == prev) ? run + 1 : 0;
            e.pc = bus.pc;
            e.instr = bus.instr;
            e.wb = {bus.reg_write, bus.mem_write, bus.write_reg, bus.write_data};
            q.push_back(e);
            if (q.size() > DEPTH) void'(q.pop_front());
            m_cyc++;
            if (bus.reg_write || bus.mem_write) m_ret++;
            hit_t = (mode == 1) && (bus.pc == trig_pc);
            hit_h = (run >= HALT_IDLE - 1);
            if (hit_t) m_trig = 1;
            if (hit_h) begin
                m_halt = 1;
                mode = 3;
            end else if (hit_t) begin
                post_left = POST_CNT;
                mode = (POST_CNT == 0) ? 3 : 2;
            end else if (mode == 2) begin
                post_left--;
                if (post_left == 0) mode = 3;
            end
        end
        prev = bus.pc;
    endfunction

    function automatic longint sat(longint v);
        return (v > (2**SAT_W - 1)) ? longint'(2**SAT_W - 1) : v;
    endfunction

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("count", 64'(count), 64'(q.size()));
            check("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
            check("retire_cnt", 64'(retire_cnt), 64'(m_ret));
            check("triggered", 64'(triggered), 64'(m_trig));
            check("halted", 64'(halted), 64'(m_halt));
            check("done", 64'(done), 64'(mode == 3));
            check("sat_cycle_cnt", 64'(s_cyc), 64'(sat(m_cyc)));
            check("sat_retire_cnt", 64'(s_ret), 64'(sat(m_ret)));
            check("sat_count", 64'(s_count), 64'(q.size()));
            if (int'(rd_idx) < q.size()) begin
                check("rd_pc", 64'(rd_pc), 64'(q[rd_idx].pc));
                check("rd_instr", 64'(rd_instr), 64'(q[rd_idx].instr));
                check("rd_wb", 64'(rd_wb), 64'(q[rd_idx].wb));
                check("sat_rd_pc", 64'(s_rd_pc), 64'(q[rd_idx].pc));
                check("sat_rd_instr", 64'(s_rd_instr), 64'(q[rd_idx].instr));
                check("sat_rd_wb", 64'(s_rd_wb), 64'(q[rd_idx].wb));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic [31:0] p, input bit rw, input bit mw, input bit a, input logic [3:0] idx);
        bus.pc = p;
        bus.instr = $urandom;
        bus.reg_write = rw;
        bus.mem_write = mw;
        bus.write_reg = 5'($urandom);
        bus.write_data = $urandom;
        arm = a;
        rd_idx = idx;
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic peek(input string name, input logic [3:0] idx, input logic [31:0] exp_pc);
        rd_idx = idx;
        #1;
        check(name, 64'(rd_pc), 64'(exp_pc));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] cur_pc;
        int          hold_left;
        bit          rw, mw;
        model_reset();
        bus.pc = '0; bus.instr = '0; bus.reg_write = 0; bus.mem_write = 0;
        bus.write_reg = '0; bus.write_data = '0;
        arm = 0; trig_pc = 32'h100; rd_idx = '0;
        chk_en = 1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_count", 64'(count), 64'd0);
        check("reset_cycle", 64'(cycle_cnt), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        reset_n = 1'b1;

        // Trigger at pc 0x40 (17th capture), eight post entries, then DONE.
        trig_pc = 32'h40;
        tick(32'h1234, 0, 0, 1, 0);
        for (int i = 0; i < 25; i++) tick(32'(i * 4), 0, 0, 0, 4'($urandom));
        check("t2_done", 64'(done), 64'd1);
        check("t2_trig", 64'(triggered), 64'd1);
        peek("t2_idx7", 7, 32'h40);
        peek("t2_idx15", 15, 32'h60);
        repeat (3) tick(32'h700, 1, 0, 0, 0);
        check("t2_cycle_frozen", 64'(cycle_cnt), 64'd25);

        // Wrap with an unreachable trigger.
        trig_pc = 32'h100;
        tick(32'h1234, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) tick(32'(i * 4), 0, 0, 0, 4'($urandom));
        check("t1_count", 64'(count), 64'd16);
        check("t1_done", 64'(done), 64'd0);
        peek("t1_idx0", 0, 32'h10);
        peek("t1_idx15", 15, 32'h4c);

        // Hold pc: halted on the eighth consecutive identical sample.
        for (int i = 0; i < 7; i++) tick(32'h20, 0, 0, 0, 0);
        check("t3_not_yet", 64'(halted), 64'd0);
        tick(32'h20, 0, 0, 0, 0);
        check("t3_halted", 64'(halted), 64'd1);
        check("t3_done", 64'(done), 64'd1);
        check("t3_cycle", 64'(cycle_cnt), 64'd28);
        repeat (3) tick(32'h20, 1, 1, 0, 0);
        check("t3_cycle_frozen", 64'(cycle_cnt), 64'd28);

        // Retire accounting: reg_write on 1,4,7; mem_write on 2,5.
        tick(32'h500, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++)
            tick(32'(32'h600 + i * 4), (i == 1 || i == 4 || i == 7), (i == 2 || i == 5), 0, 0);
        check("t4_retire", 64'(retire_cnt), 64'd5);
        check("t4_cycle", 64'(cycle_cnt), 64'd10);
        rd_idx = 1; #1; check("t4_wb_rw", 64'(rd_wb[38:37]), 64'b10);
        rd_idx = 2; #1; check("t4_wb_mw", 64'(rd_wb[38:37]), 64'b01);
        rd_idx = 3; #1; check("t4_wb_none", 64'(rd_wb[38:37]), 64'b00);

        // Trigger and halt on the same sample.
        for (int i = 0; i < 7; i++) tick(32'h300, 0, 0, 0, 0);
        check("t5_trig_before", 64'(triggered), 64'd0);
        trig_pc = 32'h300;
        tick(32'h300, 0, 0, 0, 0);
        check("t5_trig", 64'(triggered), 64'd1);
        check("t5_halt", 64'(halted), 64'd1);
        check("t5_done", 64'(done), 64'd1);
        repeat (3) tick(32'h300, 0, 0, 0, 0);
        check("t5_cycle", 64'(cycle_cnt), 64'd18);

        // Reset in the middle of the post window, then a fresh capture.
        trig_pc = 32'h40;
        tick(32'h999, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) tick(32'(i * 4), 0, 0, 0, 0);
        check("t6_in_post", 64'(done), 64'd0);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("t6_rst_count", 64'(count), 64'd0);
        check("t6_rst_cycle", 64'(cycle_cnt), 64'd0);
        check("t6_rst_trig", 64'(triggered), 64'd0);
        #1;
        reset_n = 1'b1;
        tick(32'h999, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) tick(32'(i * 4), 1, 0, 0, 0);
        check("t6_count", 64'(count), 64'd3);
        check("t6_retire", 64'(retire_cnt), 64'd3);

        // Random commits with occasional holds, arms and resets.
        hold_left = 0;
        cur_pc = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            if (hold_left > 0) begin
                hold_left--;
            end else begin
                cur_pc = 32'($urandom_range(0, 15) * 4);
                if ($urandom_range(0, 24) == 0) hold_left = $urandom_range(2, 12);
            end
            rw = ($urandom_range(0, 2) == 0);
            mw = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) begin
                trig_pc = 32'($urandom_range(0, 15) * 4);
                tick(cur_pc, rw, mw, 1, 4'($urandom));
            end else begin
                tick(cur_pc, rw, mw, 0, 4'($urandom));
            end
        end

        @(negedge clock);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
